// File: rtl/mips_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_irq_ctrl
// Purpose  : Interrupt controller between five external interrupt lines and a
//            MIPS core. Rising edges on int_in latch into PENDING. The lowest
//            index set in PENDING & MASK is requested via irq/irq_cause/
//            irq_vector. No further request is raised until the core signals
//            eret. MASK, PENDING and CAUSE are readable and writable on a small
//            register port.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            int_in     - raw interrupt lines; a rising edge is an event
//            irq        - request to core
//            irq_cause  - index of the requested or serviced source
//            irq_vector - VEC_BASE + (irq_cause << VEC_STRIDE_LOG2)
//            irq_ack    - core accepts the request (pulse)
//            eret       - core leaves the handler (pulse)
//            bus_we/bus_addr/bus_wdata/bus_rdata - register port
//                       0: MASK (R/W), 1: PENDING (R/W1C),
//                       2: CAUSE {state[10:9], irq[8], cause[2:0]}, 3: zero
// Options  : MIPS_IRQ_SYNC_EN - adds a two-flop synchronizer on int_in
// Revision : 1.0 - initial release
// ============================================================================
module mips_irq_ctrl #(
    parameter int          NUM_INT         = 5,
    parameter logic [31:0] VEC_BASE        = 32'h0000_0180,
    parameter int          VEC_STRIDE_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_in,
    output logic               irq,
    output logic [2:0]         irq_cause,
    output logic [31:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               eret,
    input  logic               bus_we,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    localparam logic [NUM_INT-1:0] c_one = {{(NUM_INT-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_irq;
    logic [2:0]         r_cause;
    logic [NUM_INT-1:0] r_mask;
    logic [NUM_INT-1:0] r_pending;
    logic [NUM_INT-1:0] r_int_q;

    logic [NUM_INT-1:0] w_int_src;
    logic [NUM_INT-1:0] w_edge;
    logic [NUM_INT-1:0] w_active;
    logic [NUM_INT-1:0] w_wr_clr;
    logic [NUM_INT-1:0] w_ack_clr;
    logic [2:0]         w_win;
    logic               w_any;
    logic               w_ack_take;
    logic               w_unused_wdata;

`ifdef MIPS_IRQ_SYNC_EN
    // Two-flop synchronizer for asynchronous interrupt lines.
    logic [NUM_INT-1:0] r_sync1;
    logic [NUM_INT-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= int_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_int_src = r_sync2;
`else
    assign w_int_src = int_in;
`endif

    assign w_edge     = w_int_src & ~r_int_q;
    assign w_active   = r_pending & r_mask;
    assign w_any      = |w_active;
    assign w_ack_take = (r_state == S_REQ) && irq_ack;

    // Clears from W1C writes and from the ack. New edges are ORed in after
    // the clear, so a simultaneous set wins.
    assign w_wr_clr  = (bus_we && (bus_addr == 2'd1)) ? bus_wdata[NUM_INT-1:0] : '0;
    assign w_ack_clr = w_ack_take ? (c_one << r_cause) : '0;

    // Only the low NUM_INT write-data bits map to register fields.
    assign w_unused_wdata = ^bus_wdata[31:NUM_INT];

    // Lowest index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_win = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_irq     <= 1'b0;
            r_cause   <= '0;
            r_mask    <= '0;
            r_pending <= '0;
            r_int_q   <= '0;
        end else begin
            r_int_q   <= w_int_src;
            r_pending <= (r_pending & ~(w_wr_clr | w_ack_clr)) | w_edge;

            if (bus_we && (bus_addr == 2'd0)) begin
                r_mask <= bus_wdata[NUM_INT-1:0];
            end

            // irq_cause is frozen from entry to REQ until the next IDLE
            // arbitration, so mask or W1C changes cannot retarget a request.
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cause <= w_win;
                        r_irq   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (irq_ack) begin
                        r_irq   <= 1'b0;
                        r_state <= S_SVC;
                    end
                end
                S_SVC: begin
                    if (eret) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq        = r_irq;
    assign irq_cause  = r_cause;
    assign irq_vector = VEC_BASE + ({29'd0, r_cause} << VEC_STRIDE_LOG2);

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            2'd0: bus_rdata[NUM_INT-1:0] = r_mask;
            2'd1: bus_rdata[NUM_INT-1:0] = r_pending;
            2'd2: begin
                bus_rdata[2:0]  = r_cause;
                bus_rdata[8]    = r_irq;
                bus_rdata[10:9] = r_state;
            end
            default: bus_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_irq_ctrl
// Purpose  : Self-checking bench for mips_irq_ctrl. Expected causes are pushed
//            to a queue when interrupt stimulus is driven and popped when the
//            controller raises irq. Honours MIPS_IRQ_SYNC_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_irq_ctrl;

    localparam logic [31:0] c_vec_base = 32'h0000_0180;
`ifdef MIPS_IRQ_SYNC_EN
    localparam int c_sync_lat = 2;
`else
    localparam int c_sync_lat = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  int_in;
    logic        irq;
    logic [2:0]  irq_cause;
    logic [31:0] irq_vector;
    logic        irq_ack;
    logic        eret;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    mips_irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .int_in     (int_in),
        .irq        (irq),
        .irq_cause  (irq_cause),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .eret       (eret),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic wait_irq(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    // Pops the next expected cause and compares it against the live request.
    task automatic sb_check_request(input string name);
        logic [2:0]  exp_c;
        logic [31:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: request cause=%0d with empty scoreboard", name, irq_cause);
        end else begin
            exp_c = exp_q.pop_front();
            exp_v = c_vec_base + ({29'd0, exp_c} << 3);
            if (irq !== 1'b1 || irq_cause !== exp_c || irq_vector !== exp_v) begin
                failures++;
                $display("FAIL %s: irq=%b cause=%0d vector=%h, expected irq=1 cause=%0d vector=%h",
                         name, irq, irq_cause, irq_vector, exp_c, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (irq !== 1'b0 || irq_cause !== 3'd0 || irq_vector !== c_vec_base) begin
            failures++;
            $display("FAIL reset_outputs: irq=%b cause=%0d vector=%h, expected 0/0/%h",
                     irq, irq_cause, irq_vector, c_vec_base);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_pending: got %h expected 0", d); end
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h1F) begin failures++; $display("FAIL mask_readback: got %h expected 1f", d); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL cause_readback: got %h expected 0", d); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL addr3_readback: got %h expected 0", d); end
        // Asynchronous reset: observe MASK clear between clock edges.
        bus_addr = 2'd0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin failures++; $display("FAIL async_reset_mask: got %h expected 0", bus_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] d;
        bus_write(2'd0, 32'h1F);
        int_in = 5'b00100;
        exp_q.push_back(3'd2);
        repeat (c_sync_lat + 1) tick();
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h4 || irq !== 1'b0) begin
            failures++;
            $display("FAIL single_pending: pending=%h irq=%b expected 4/0", d, irq);
        end
        tick();
        sb_check_request("single_request");
        checks++;
        if (irq_vector !== 32'h0000_0190) begin
            failures++;
            $display("FAIL single_vector: got %h expected 00000190", irq_vector);
        end
        bus_read(2'd2, d);
        checks++;
        if ((d & ~32'h600) !== 32'h102) begin
            failures++;
            $display("FAIL single_cause_reg: got %h expected 102 outside state bits", d);
        end
        int_in = 5'b0;
        pulse_ack();
        bus_read(2'd1, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            failures++;
            $display("FAIL single_ack: irq=%b pending=%h expected 0/0", irq, d);
        end
        pulse_eret();
    endtask

    task automatic test_priority();
        bit seen;
        int_in = 5'b10010;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd4);
        wait_irq(10, seen);
        int_in = 5'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL prio_first_timeout: irq=%b expected 1", irq); void'(exp_q.pop_front()); end
        else sb_check_request("prio_first");
        pulse_ack();
        pulse_eret();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL prio_gap: irq=%b expected 0 right after eret", irq); end
        tick();
        sb_check_request("prio_second");
        // eret alone in REQ must be ignored.
        pulse_eret();
        checks++;
        if (irq !== 1'b1 || irq_cause !== 3'd4) begin
            failures++;
            $display("FAIL eret_in_req: irq=%b cause=%0d expected 1/4", irq, irq_cause);
        end
        // ack and eret together: ack taken, eret ignored -> stays in SVC.
        irq_ack = 1'b1; eret = 1'b1; tick(); irq_ack = 1'b0; eret = 1'b0;
        int_in = 5'b00100;
        repeat (c_sync_lat + 3) tick();
        int_in = 5'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL ack_eret_same: irq=%b expected 0 while servicing", irq); end
        // ack in SVC ignored; line 2 still pending, served after eret.
        pulse_ack();
        pulse_eret();
        exp_q.push_back(3'd2);
        tick();
        sb_check_request("prio_after_svc");
        pulse_ack();
        pulse_eret();
    endtask

    task automatic test_masking();
        logic [31:0] d;
        bus_write(2'd0, 32'h0);
        int_in = 5'b01000;
        repeat (c_sync_lat + 1) tick();
        int_in = 5'b0;
        repeat (3) tick();
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h8 || irq !== 1'b0) begin
            failures++;
            $display("FAIL masked_pending: pending=%h irq=%b expected 8/0", d, irq);
        end
        bus_write(2'd0, 32'h08);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL mask_enable_early: irq=%b expected 0", irq); end
        exp_q.push_back(3'd3);
        tick();
        sb_check_request("mask_enable");
        // Neither a mask clear nor a W1C withdraws a live request.
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h08);
        checks++;
        if (irq !== 1'b1 || irq_cause !== 3'd3) begin
            failures++;
            $display("FAIL req_hold: irq=%b cause=%0d expected 1/3", irq, irq_cause);
        end
        pulse_ack();
        pulse_eret();
        int_in = 5'b01000;
        repeat (c_sync_lat + 1) tick();
        int_in = 5'b0;
        tick();
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_idle: pending=%h irq=%b expected 0/0", d, irq);
        end
    endtask

    task automatic test_no_nest();
        logic [31:0] d;
        bit seen;
        bus_write(2'd0, 32'h1F);
        int_in = 5'b00001;
        exp_q.push_back(3'd0);
        wait_irq(10, seen);
        int_in = 5'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL nest_first_timeout: irq=%b expected 1", irq); void'(exp_q.pop_front()); end
        else sb_check_request("nest_first");
        pulse_ack();
        int_in = 5'b00001;
        repeat (c_sync_lat + 3) tick();
        int_in = 5'b0;
        tick();
        bus_read(2'd1, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h1) begin
            failures++;
            $display("FAIL no_nest: irq=%b pending=%h expected 0/1", irq, d);
        end
        pulse_eret();
        exp_q.push_back(3'd0);
        tick();
        sb_check_request("nest_after_eret");
        // New edge on line 0 lands on the same edge as the ack.
        int_in = 5'b00001;
        repeat (c_sync_lat) tick();
        pulse_ack();
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL set_wins_ack: pending=%h irq=%b expected 1/0", d, irq);
        end
        int_in = 5'b0;
        pulse_eret();
        exp_q.push_back(3'd0);
        tick();
        sb_check_request("set_wins_request");
        pulse_ack();
        pulse_eret();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit seen;
        int_in = 5'b00010;
        exp_q.push_back(3'd1);
        wait_irq(10, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_req_timeout: irq=%b expected 1", irq); void'(exp_q.pop_front()); end
        else sb_check_request("mid_req");
        rst = 1'b0;
        int_in = 5'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || irq_cause !== 3'd0 || irq_vector !== c_vec_base) begin
            failures++;
            $display("FAIL mid_reset_async: irq=%b cause=%0d vector=%h expected 0/0/%h",
                     irq, irq_cause, irq_vector, c_vec_base);
        end
        tick();
        rst = 1'b1;
        bus_write(2'd0, 32'h1F);
        repeat (5) tick();
        bus_read(2'd1, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_quiet: irq=%b pending=%h expected 0/0", irq, d);
        end
        int_in = 5'b10000;
        exp_q.push_back(3'd4);
        wait_irq(10, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL post_reset_edge_timeout: irq=%b expected 1", irq); void'(exp_q.pop_front()); end
        else sb_check_request("post_reset_edge");
        // Line held high across reset release registers as an edge.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (c_sync_lat + 1) tick();
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h10 || irq !== 1'b0) begin
            failures++;
            $display("FAIL high_at_release: pending=%h irq=%b expected 10/0", d, irq);
        end
        int_in = 5'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0; int_in = '0; irq_ack = 1'b0; eret = 1'b0;
        bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_no_nest();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mips_irq_ctrl.md
# mips_irq_ctrl

Interrupt controller between the five external interrupt lines and the MIPS core. Edge-detects and latches each line, applies a software-written enable mask, and picks the highest-priority pending source. It then raises a single request to the core with a cause code and handler vector, and holds off further requests until the core signals return from the handler. Mask, pending and cause registers are exposed on a small memory-mapped slave port driven by the core's data-memory path.

## Interface
- `NUM_INT`, 5: number of interrupt lines. Fixed at 5; other values are unsupported.
- `VEC_BASE`, 32'h0000_0180: handler base address.
- `VEC_STRIDE_LOG2`, 3: per-cause vector spacing is `2**VEC_STRIDE_LOG2` bytes.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `int_in`  input  5  raw interrupt lines, level; a rising edge is an event.
- `irq`  output  1  interrupt request to the core.
- `irq_cause`  output  3  index of the source being requested or serviced.
- `irq_vector`  output  32  `VEC_BASE + (irq_cause << VEC_STRIDE_LOG2)`.
- `irq_ack`  input  1  core accepts the request (single-cycle pulse).
- `eret`  input  1  core leaves the handler (single-cycle pulse).
- `bus_we`  input  1  register write strobe.
- `bus_addr`  input  2  register select.
- `bus_wdata`  input  32  write data.
- `bus_rdata`  output  32  read data, combinational from `bus_addr`.

## Operation
- Registers, with unused bits reading 0:
  - Address 0, MASK (5 bits, R/W). A 1 enables that line.
  - Address 1, PENDING (5 bits, R/W1C).
  - Address 2, CAUSE: bits 2:0 are `irq_cause`, bit 8 is `irq`, bits 10:9 are the state encoding.
  - Address 3 reads 0; writes to it are ignored.
- Edge detect:
  - `int_q` holds `int_in` sampled on the previous cycle.
  - The PENDING bit for line i sets when `int_in[i] & ~int_q[i]`.
  - A level held high produces exactly one event.
- Priority: line 0 is highest. The winner is the lowest index set in `PENDING & MASK`.
- State machine:
  - IDLE: if `PENDING & MASK` is nonzero, latch the winner into `irq_cause`, set `irq`, and go to REQ.
  - REQ: `irq` stays at 1. On `irq_ack`, clear `PENDING[irq_cause]`, set `irq` to 0, and go to SVC.
  - SVC: new edges continue to latch into PENDING, but no request is raised. On `eret`, go to IDLE.
- Boundary rules:
  - PENDING set and clear on the same bit in the same cycle (by W1C or by ack): set wins.
  - Clearing a MASK bit while in REQ does not withdraw the request; `irq_cause` stays fixed until the ack.
  - A W1C clear of the requested bit while in REQ does not withdraw the request.
  - `irq_ack` is ignored in IDLE and SVC.
  - `eret` is ignored in IDLE and REQ.
  - `irq_ack` and `eret` in the same cycle in REQ: the ack is taken and the `eret` is ignored.
  - `rst` asserted mid-operation returns every register to its reset value immediately, with no clock required.
- Reset values:
  - State IDLE.
  - `irq` = 0 and `irq_cause` = 0.
  - `irq_vector` = `VEC_BASE`.
  - MASK = 0 and PENDING = 0.
  - `int_q` = 0. Lines already high when `rst` releases therefore register as an edge on the first clock.

## Timing
- The `int_in` rising edge is set up before clock edge k:
  - `PENDING` is 1 after edge k.
  - `irq` is 1 after edge k+1, provided the line is enabled and the state is IDLE.
- `irq_ack` sampled at edge m: `irq` is 0 and the state is SVC after edge m.
- `eret` sampled at edge m: the state is IDLE after edge m. A request for still-pending enabled sources follows at edge m+1.
- Writing a MASK bit that enables an already-pending line: `irq` rises one edge after the write edge.
- `bus_rdata` is valid in the same cycle as `bus_addr`. Writes take effect at the clock edge.

## Configuration
- `MIPS_IRQ_SYNC_EN` defined:
  - Each `int_in` bit passes through a two-flop synchronizer, reset to 0, before edge detect.
  - Every `int_in`-to-`PENDING` and `int_in`-to-`irq` latency grows by 2 cycles (`irq` after edge k+3).
- `MIPS_IRQ_SYNC_EN` not defined: `int_in` feeds edge detect directly and the latencies above apply.

## Test plan
- Reset and read-back:
  - Stimulus: write MASK=5'h1F, then read addresses 0 to 3.
  - Required: MASK reads 32'h1F, PENDING reads 0, CAUSE reads 0, address 3 reads 0.
  - Required: after `rst` pulses low, MASK reads 0 with no clock applied.
- Single interrupt:
  - Stimulus: MASK=5'h1F, pulse `int_in[2]`.
  - Required: `irq`=1 two edges later (four with `MIPS_IRQ_SYNC_EN`), `irq_cause`=2, `irq_vector`=32'h0000_0190.
  - Stimulus: `irq_ack`.
  - Required: `irq`=0 and PENDING=0.
- Priority and queuing:
  - Stimulus: MASK=5'h1F, raise `int_in`=5'b10010 together.
  - Required: cause 1 is served first.
  - Stimulus: ack and `eret`.
  - Required: `irq` rises again one edge after `eret` with cause 4.
- Masking:
  - Stimulus: MASK=5'h00, pulse `int_in[3]`.
  - Required: PENDING=5'h08 and `irq` stays 0.
  - Stimulus: write MASK=5'h08.
  - Required: `irq` rises one edge later with cause 3.
  - Stimulus: W1C 5'h08 in IDLE.
  - Required: PENDING clears.
- No nesting, set-wins:
  - Stimulus: an edge on line 0 during SVC.
  - Required: `irq` stays 0 until `eret`.
  - Stimulus: `irq_ack` coinciding with a new edge on the same line.
  - Required: that PENDING bit remains 1.
- Reset mid-request:
  - Stimulus: drop `rst` while in REQ.
  - Required: `irq` drops with no clock edge, and after release no request appears until a new edge arrives.
